// File: rtl/golden_nonce_queue.sv
// rtl/golden_nonce_queue.sv - golden-ticket result FIFO with nonce offset correction (optional GOLDEN_NONCE_DEDUP_EN)
module golden_nonce_queue #(
  parameter logic [31:0] NONCE_OFFSET = 32'd131,
  parameter int          DEPTH_LOG2   = 3,
  parameter int          JOB_W        = 8
) (
  input  logic                  hash_clk,
  input  logic                  reset_n,
  input  logic                  found_valid,
  input  logic [31:0]           found_nonce,
  input  logic [JOB_W-1:0]      job_id,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [31:0]           out_nonce,
  output logic [JOB_W-1:0]      out_job,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [31:0]      mem_nonce [DEPTH];
  logic [JOB_W-1:0] mem_job   [DEPTH];

  logic [PW-1:0]    wr_ptr, rd_ptr, wr_next, rd_next, count;
  logic [31:0]      fixed_nonce, head_nonce;
  logic [JOB_W-1:0] head_job;
  logic             full, pop, dup, push_ok, drop;

`ifdef GOLDEN_NONCE_DEDUP_EN
  logic [31:0]      last_nonce;
  logic [JOB_W-1:0] last_job;
  logic             last_valid;
`endif

  // Push/pop decisions, next pointers and the entry that will sit at the head next cycle
  always_comb begin
    fixed_nonce = found_nonce - NONCE_OFFSET;
    count       = wr_ptr - rd_ptr;
    full        = count[DEPTH_LOG2];
    pop         = out_valid & out_ready;
`ifdef GOLDEN_NONCE_DEDUP_EN
    dup = last_valid && (last_nonce == fixed_nonce) && (last_job == job_id);
`else
    dup = 1'b0;
`endif
    push_ok = found_valid & ~flush & ~dup & (~full | pop);
    drop    = found_valid & ~flush & ~dup & full & ~pop;
    wr_next = wr_ptr + PW'(push_ok);
    rd_next = rd_ptr + PW'(pop);
    // The slot being written this cycle becomes the head only when the FIFO drains to it
    if (push_ok && (wr_ptr == rd_next)) begin
      head_nonce = fixed_nonce;
      head_job   = job_id;
    end else begin
      head_nonce = mem_nonce[rd_next[DEPTH_LOG2-1:0]];
      head_job   = mem_job[rd_next[DEPTH_LOG2-1:0]];
    end
  end

  // Entry storage; contents need no reset since pointers define validity
  always_ff @(posedge hash_clk) begin
    if (reset_n && push_ok) begin
      mem_nonce[wr_ptr[DEPTH_LOG2-1:0]] <= fixed_nonce;
      mem_job[wr_ptr[DEPTH_LOG2-1:0]]   <= job_id;
    end
  end

  // Pointers plus registered head/level outputs
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_nonce <= '0;
      out_job   <= '0;
      level     <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      level     <= '0;
    end else begin
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      level     <= wr_next - rd_next;
      out_valid <= (wr_next != rd_next);
      if (wr_next != rd_next) begin
        out_nonce <= head_nonce;
        out_job   <= head_job;
      end
    end
  end

  // Saturating count of results lost to a full FIFO; survives flush
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

`ifdef GOLDEN_NONCE_DEDUP_EN
  // Remember the last accepted result so a re-flagged ticket is ignored
  always_ff @(posedge hash_clk) begin
    if (!reset_n || flush) begin
      last_valid <= 1'b0;
      last_nonce <= '0;
      last_job   <= '0;
    end else if (push_ok) begin
      last_valid <= 1'b1;
      last_nonce <= fixed_nonce;
      last_job   <= job_id;
    end
  end
`endif

endmodule
